// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: push/pop stream to RAM strobes, addresses and data.
// Latency: write same cycle as push; pop_data/pop_valid one cycle after an accepted pop.
// Backpressure: push ignored while full, pop ignored while empty; both raise sticky error flags.
module dpram_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_ful,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_enb,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count_q;
    logic            push_acc;
    logic            pop_acc;

    // Flags come from the registered count, so they trail the accept by one cycle.
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign almost_ful = (count_q >= AF_C);
    assign count      = count_q;

    // Gating with rst keeps every RAM strobe low while reset is held.
    assign push_acc = rst & push & ~full;
    assign pop_acc  = rst & pop & ~empty;

    assign ram_wr     = push_acc;
    assign ram_rd     = pop_acc;
    assign ram_enb    = push_acc | pop_acc;
    assign ram_w_addr = wr_ptr[ADDR_W-1:0];
    assign ram_r_addr = rd_ptr[ADDR_W-1:0];
    assign ram_w_data = push_data;
    assign pop_data   = ram_r_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            pop_valid <= pop_acc;
            if (push && full)  overflow  <= 1'b1;
            if (pop && empty)  underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: table vectors, directed corner sequences and random traffic
// against a queue-based reference model, with a registered-read RAM attached.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_ful;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_enb;
    logic          ram_wr;
    logic          ram_rd;
    logic [AW-1:0] ram_w_addr;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_ful(almost_ful), .count(count), .overflow(overflow), .underflow(underflow),
        .ram_enb(ram_enb), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_w_addr(ram_w_addr),
        .ram_r_addr(ram_r_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
    );

    // Dual-port RAM with a registered read port
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q = '0;
    assign ram_r_data = rdata_q;
    always @(posedge clk) begin
        if (ram_enb && ram_wr) mem[ram_w_addr] <= ram_w_data;
        if (ram_enb && ram_rd) rdata_q <= mem[ram_r_addr];
    end

    // Reference model
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_pv;
    logic [DW-1:0] m_pd;
    int            m_wcnt, m_rcnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int sz;
        bit ewr, erd;
        sz  = q.size();
        ewr = rst && push && (sz < DEPTH);
        erd = rst && pop && (sz > 0);
        chk("count", int'(count), sz);
        chk("full", int'(full), int'(sz == DEPTH));
        chk("empty", int'(empty), int'(sz == 0));
        chk("almost_ful", int'(almost_ful), int'(sz >= AF));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
        chk("pop_valid", int'(pop_valid), int'(m_pv));
        if (m_pv) chk("pop_data", int'(pop_data), int'(m_pd));
        chk("ram_wr", int'(ram_wr), int'(ewr));
        chk("ram_rd", int'(ram_rd), int'(erd));
        chk("ram_enb", int'(ram_enb), int'(ewr || erd));
        if (ewr) begin
            chk("ram_w_addr", int'(ram_w_addr), m_wcnt);
            chk("ram_w_data", int'(ram_w_data), int'(push_data));
        end
        if (erd) chk("ram_r_addr", int'(ram_r_addr), m_rcnt);
    endtask

    task automatic model_update();
        int sz;
        sz = q.size();
        if (!rst) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_pv = 0;
            m_wcnt = 0; m_rcnt = 0;
        end else begin
            if (push && sz == DEPTH) m_ovf = 1;
            if (pop && sz == 0)      m_unf = 1;
            m_pv = pop && (sz > 0);
            if (m_pv) begin
                m_pd   = q.pop_front();
                m_rcnt = (m_rcnt + 1) % DEPTH;
            end
            if (push && sz < DEPTH) begin
                q.push_back(push_data);
                m_wcnt = (m_wcnt + 1) % DEPTH;
            end
        end
    endtask

    // One clock: drive, check pre-edge state on negedge, advance model at posedge, settle.
    task automatic cycle(input logic r, input logic pu, input logic po, input logic [DW-1:0] d);
        rst = r; push = pu; pop = po; push_data = d;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic          r, pu, po;
        logic [DW-1:0] d;
        int            cnt;
        logic          e, f, o, u, pv;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{r:0, pu:0, po:0, d:8'h00, cnt:0, e:1, f:0, o:0, u:0, pv:0};
        tbl[1] = '{r:0, pu:1, po:1, d:8'h33, cnt:0, e:1, f:0, o:0, u:0, pv:0};
        tbl[2] = '{r:1, pu:0, po:1, d:8'h00, cnt:0, e:1, f:0, o:0, u:1, pv:0};
        tbl[3] = '{r:1, pu:1, po:0, d:8'h55, cnt:1, e:0, f:0, o:0, u:1, pv:0};
        tbl[4] = '{r:1, pu:1, po:1, d:8'h66, cnt:1, e:0, f:0, o:0, u:1, pv:1};
        tbl[5] = '{r:1, pu:0, po:1, d:8'h00, cnt:0, e:1, f:0, o:0, u:1, pv:1};
        tbl[6] = '{r:0, pu:0, po:0, d:8'h00, cnt:0, e:1, f:0, o:0, u:0, pv:0};

        rst = 0; push = 0; pop = 0; push_data = '0;
        m_ovf = 0; m_unf = 0; m_pv = 0; m_pd = '0; m_wcnt = 0; m_rcnt = 0;
        @(posedge clk);
        model_update();
        #1;

        // Table-driven vectors, expected state after each edge
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].r, tbl[i].pu, tbl[i].po, tbl[i].d);
            chk("tbl_count", int'(count), tbl[i].cnt);
            chk("tbl_empty", int'(empty), int'(tbl[i].e));
            chk("tbl_full", int'(full), int'(tbl[i].f));
            chk("tbl_overflow", int'(overflow), int'(tbl[i].o));
            chk("tbl_underflow", int'(underflow), int'(tbl[i].u));
            chk("tbl_pop_valid", int'(pop_valid), int'(tbl[i].pv));
            if (i == 4) chk("tbl_pop_data", int'(pop_data), 32'h55);
            if (i == 5) chk("tbl_pop_data", int'(pop_data), 32'h66);
        end

        // Fill and drain
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 0, DW'(8'h10 + i));
            chk("fill_af", int'(almost_ful), int'(i + 1 >= AF));
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 1, 0);
            chk("drain_data", int'(pop_data), 32'h10 + i);
        end
        cycle(1, 0, 0, 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_valid_low", int'(pop_valid), 0);

        // Underflow on empty pop, sticky
        cycle(1, 0, 1, 0);
        chk("unf_set", int'(underflow), 1);
        chk("unf_count", int'(count), 0);
        cycle(1, 0, 0, 0);
        chk("unf_sticky", int'(underflow), 1);

        // Simultaneous push/pop at count 5, then at full
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, DW'(8'h40 + i));
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 8'hAA);
        chk("simul_count", int'(count), 5);
        for (int i = 0; i < 11; i++) cycle(1, 1, 0, DW'(8'h50 + i));
        chk("simul_full", int'(full), 1);
        cycle(1, 1, 1, 8'hEE);
        chk("full_pp_count", int'(count), 15);
        chk("full_pp_ovf", int'(overflow), 1);
        cycle(1, 1, 0, 8'h77);
        cycle(1, 1, 0, 8'h78);
        chk("ovf_count", int'(count), 16);
        cycle(1, 0, 0, 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Pointer wrap
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, DW'(8'h60 + i));
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, DW'(8'h80 + i));
        chk("wrap_count", int'(count), 10);
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 0);

        // Mid-operation reset
        for (int i = 0; i < 7; i++) cycle(1, 1, 0, DW'(8'h90 + i));
        chk("mid_count7", int'(count), 7);
        cycle(0, 0, 0, 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        cycle(1, 0, 1, 0);
        chk("mid_rst_unf", int'(underflow), 1);
        chk("mid_rst_valid", int'(pop_valid), 0);

        // Random traffic with shifting push/pop bias and rare resets
        for (int ph = 0; ph < 8; ph++) begin
            int ppu, ppo;
            ppu = (ph % 2 == 0) ? 75 : 35;
            ppo = (ph % 2 == 0) ? 35 : 75;
            if (ph >= 6) begin ppu = 50; ppo = 50; end
            for (int c = 0; c < 100; c++) begin
                cycle(logic'($urandom_range(0, 79) != 0),
                      logic'($urandom_range(0, 99) < ppu),
                      logic'($urandom_range(0, 99) < ppo),
                      DW'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
